// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader: FSM states,
// bytes-per-word and the status encodings presented to the host.
package loader_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int BIDX_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_LOAD, S_DONE, S_ERR} state_t;

  localparam logic [1:0] STAT_IDLE = 2'b00;
  localparam logic [1:0] STAT_LOAD = 2'b01;
  localparam logic [1:0] STAT_DONE = 2'b10;
  localparam logic [1:0] STAT_ERR  = 2'b11;

  function automatic logic [1:0] status_of(state_t s);
    case (s)
      S_LEN, S_LOAD: status_of = STAT_LOAD;
      S_DONE:        status_of = STAT_DONE;
      S_ERR:         status_of = STAT_ERR;
      default:       status_of = STAT_IDLE;
    endcase
  endfunction
endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word assembler. word is valid in the same cycle as the
// final byte's rx_valid, flagged by word_done; clear has priority over rx_valid.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [31:0] word,
  output logic        word_done
);
  logic [23:0]       shift_q, shift_d;
  logic [BIDX_W-1:0] idx_q, idx_d;

  // The three earlier bytes sit above the byte arriving this cycle.
  assign word      = {shift_q, rx_data};
  assign word_done = rx_valid && !clear && (idx_q == BIDX_W'(BYTES_PER_WORD - 1));

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clear) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (rx_valid) begin
      shift_d = {shift_q[15:0], rx_data};
      idx_d   = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end
endmodule

// File: rtl/prog_loader.sv
// UART program loader: receives a 32-bit big-endian word count N followed by
// N instruction words, writes them to instruction memory, then releases the CPU.
module prog_loader
  import loader_pkg::*;
#(
  parameter int INST_MEM_WIDTH = 15
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      load_start,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic                      imem_we,
  output logic [INST_MEM_WIDTH-1:0] imem_addr,
  output logic [31:0]               imem_wdata,
  output logic                      cpu_run,
  output logic [1:0]                status
);
  localparam logic [32:0] MAX_WORDS = 33'd1 << INST_MEM_WIDTH;

  state_t                    state_q, state_d;
  logic [31:0]               n_q, n_d;
  logic [31:0]               wcnt_q, wcnt_d;
  logic                      we_q, we_d;
  logic [INST_MEM_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]               wdata_q, wdata_d;

  logic        start_ok, busy, pk_valid;
  logic [31:0] pk_word;
  logic        pk_done;

  assign start_ok = load_start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign busy     = (state_q == S_LEN) || (state_q == S_LOAD);
  assign pk_valid = rx_valid && busy;

  byte_packer u_packer (
    .clk       (CLK),
    .rst       (RST),
    .clear     (start_ok),
    .rx_valid  (pk_valid),
    .rx_data   (rx_data),
    .word      (pk_word),
    .word_done (pk_done)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    // Address advances in the cycle after each write pulse; wraps on a full memory.
    if (we_q) addr_d = addr_q + 1'b1;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_ok) begin
          state_d = S_LEN;
          wcnt_d  = '0;
          addr_d  = '0;
        end
      end
      S_LEN: begin
        if (pk_done) begin
          n_d = pk_word;
          if (pk_word == 32'd0)                    state_d = S_DONE;
          else if ({1'b0, pk_word} > MAX_WORDS)    state_d = S_ERR;
          else                                     state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (pk_done) begin
          we_d    = 1'b1;
          wdata_d = pk_word;
          wcnt_d  = wcnt_q + 32'd1;
          if (wcnt_q == n_q - 32'd1) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      wcnt_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_run    = (state_q == S_DONE);
  assign status     = status_of(state_q);
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: count/word framing, error and boundary
// counts, reset mid-load, ignored bytes and back-to-back bytes.
module tb_prog_loader;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        load_start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        imem_we;
  logic [14:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_run;
  logic [1:0]  status;

  int checks = 0;
  int failures = 0;

  logic [14:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int          wr_cnt = 0;
  int          base;

  prog_loader #(.INST_MEM_WIDTH(15)) dut (
    .CLK(CLK), .RST(RST), .load_start(load_start), .rx_valid(rx_valid),
    .rx_data(rx_data), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_run(cpu_run), .status(status)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (imem_we) begin
      if (wr_cnt < 64) begin
        wr_addr[wr_cnt] = imem_addr;
        wr_data[wr_cnt] = imem_wdata;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b; tick(); rx_valid = 1'b0;
  endtask

  task automatic start();
    load_start = 1'b1; tick(); load_start = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; tick(); tick();
    checks++; if (status !== 2'b00) begin failures++; $display("FAIL rst_status got=%b exp=00", status); end
    checks++; if (imem_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", imem_we); end
    checks++; if (imem_addr !== 15'd0) begin failures++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    checks++; if (imem_wdata !== 32'd0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", imem_wdata); end
    checks++; if (cpu_run !== 1'b0) begin failures++; $display("FAIL rst_run got=%b exp=0", cpu_run); end
    RST = 1'b0; tick();
  endtask

  task automatic test_two_words();
    base = wr_cnt;
    start();
    checks++; if (status !== 2'b01) begin failures++; $display("FAIL tw_len_status got=%b exp=01", status); end
    send(8'h00); send(8'h00);
    start(); // ignored while counting
    send(8'h00); send(8'h02);
    checks++; if (status !== 2'b01) begin failures++; $display("FAIL tw_load_status got=%b exp=01", status); end
    send(8'hDE); tick(); send(8'hAD); send(8'hBE); tick(); send(8'hEF);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 15'd0 || imem_wdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL tw_w0 got=we%b a%h d%h exp=we1 a0 dDEADBEEF", imem_we, imem_addr, imem_wdata); end
    checks++; if (status !== 2'b01 || cpu_run !== 1'b0) begin failures++; $display("FAIL tw_mid got=st%b run%b exp=st01 run0", status, cpu_run); end
    send(8'h01); send(8'h23); send(8'h45); send(8'h67);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 15'd1 || imem_wdata !== 32'h01234567) begin
      failures++; $display("FAIL tw_w1 got=we%b a%h d%h exp=we1 a1 d01234567", imem_we, imem_addr, imem_wdata); end
    checks++; if (status !== 2'b10 || cpu_run !== 1'b1) begin failures++; $display("FAIL tw_done got=st%b run%b exp=st10 run1", status, cpu_run); end
    tick();
    checks++; if (imem_we !== 1'b0 || imem_addr !== 15'd2 || imem_wdata !== 32'h01234567) begin
      failures++; $display("FAIL tw_after got=we%b a%h d%h exp=we0 a2 d01234567", imem_we, imem_addr, imem_wdata); end
    send(8'h99); send(8'h98); send(8'h97); send(8'h96); tick();
    checks++; if (wr_cnt - base !== 2 || wr_addr[base] !== 15'd0 || wr_addr[base+1] !== 15'd1) begin
      failures++; $display("FAIL tw_writes got=n%0d exp=n2 addrs 0,1", wr_cnt - base); end
  endtask

  task automatic test_zero();
    base = wr_cnt;
    start();
    send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    tick(); tick();
    checks++; if (status !== 2'b10 || cpu_run !== 1'b1) begin failures++; $display("FAIL zero_done got=st%b run%b exp=st10 run1", status, cpu_run); end
    checks++; if (wr_cnt - base !== 0) begin failures++; $display("FAIL zero_writes got=%0d exp=0", wr_cnt - base); end
  endtask

  task automatic test_err();
    base = wr_cnt;
    start();
    send(8'h00); send(8'h00); send(8'h80); send(8'h01);
    checks++; if (status !== 2'b11 || cpu_run !== 1'b0) begin failures++; $display("FAIL err_state got=st%b run%b exp=st11 run0", status, cpu_run); end
    for (int i = 0; i < 8; i++) send(8'(i + 1));
    tick();
    checks++; if (wr_cnt - base !== 0 || status !== 2'b11) begin failures++; $display("FAIL err_nowrite got=n%0d st%b exp=n0 st11", wr_cnt - base, status); end
    start();
    checks++; if (status !== 2'b01 || cpu_run !== 1'b0) begin failures++; $display("FAIL err_recover got=st%b run%b exp=st01 run0", status, cpu_run); end
    send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    checks++; if (status !== 2'b10) begin failures++; $display("FAIL err_reload got=%b exp=10", status); end
  endtask

  task automatic test_max_count();
    base = wr_cnt;
    start();
    send(8'h00); send(8'h00); send(8'h80); send(8'h00);
    checks++; if (status !== 2'b01) begin failures++; $display("FAIL max_status got=%b exp=01", status); end
    send(8'h55); send(8'hAA); send(8'h5A); send(8'hA5); tick();
    checks++; if (wr_cnt - base !== 1 || wr_addr[base] !== 15'd0 || wr_data[base] !== 32'h55AA5AA5) begin
      failures++; $display("FAIL max_write got=n%0d exp=n1 a0 d55AA5AA5", wr_cnt - base); end
    checks++; if (status !== 2'b01 || imem_addr !== 15'd1) begin failures++; $display("FAIL max_cont got=st%b a%h exp=st01 a1", status, imem_addr); end
    RST = 1'b1; tick(); RST = 1'b0; tick();
  endtask

  task automatic test_reset_mid();
    base = wr_cnt;
    start();
    send(8'h00); send(8'h00); send(8'h00); send(8'h03);
    send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    send(8'h50); send(8'h60);
    RST = 1'b1; load_start = 1'b1; rx_valid = 1'b1; rx_data = 8'h70; tick();
    checks++; if (status !== 2'b00 || imem_we !== 1'b0 || imem_addr !== 15'd0 || imem_wdata !== 32'd0 || cpu_run !== 1'b0) begin
      failures++; $display("FAIL rm_reset got=st%b we%b a%h d%h run%b exp=all zero", status, imem_we, imem_addr, imem_wdata, cpu_run); end
    RST = 1'b0; load_start = 1'b0; rx_valid = 1'b0;
    send(8'h80); send(8'h90); send(8'hA0); send(8'hB0); tick();
    checks++; if (wr_cnt - base !== 1 || wr_addr[base] !== 15'd0 || wr_data[base] !== 32'h10203040) begin
      failures++; $display("FAIL rm_writes got=n%0d exp=n1 a0 d10203040", wr_cnt - base); end
    checks++; if (status !== 2'b00 || imem_addr !== 15'd0) begin failures++; $display("FAIL rm_idle got=st%b a%h exp=st00 a0", status, imem_addr); end
  endtask

  task automatic test_ignore_bytes();
    base = wr_cnt;
    send(8'hAA); send(8'hBB); send(8'hCC);
    load_start = 1'b1; rx_valid = 1'b1; rx_data = 8'hFF; tick();
    load_start = 1'b0; rx_valid = 1'b0;
    send(8'h00); send(8'h00); send(8'h00); send(8'h01);
    send(8'hCA); send(8'hFE); send(8'hF0); send(8'h0D); tick();
    checks++; if (wr_cnt - base !== 1 || wr_addr[base] !== 15'd0 || wr_data[base] !== 32'hCAFEF00D) begin
      failures++; $display("FAIL ign_write got=n%0d d%h exp=n1 a0 dCAFEF00D", wr_cnt - base, wr_data[base]); end
    checks++; if (status !== 2'b10 || cpu_run !== 1'b1) begin failures++; $display("FAIL ign_done got=st%b run%b exp=st10 run1", status, cpu_run); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [0:7];
    seq = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    base = wr_cnt;
    start();
    for (int i = 0; i < 8; i++) send(seq[i]);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 15'd0 || imem_wdata !== 32'h11223344 || status !== 2'b10) begin
      failures++; $display("FAIL b2b_pulse got=we%b a%h d%h st%b exp=we1 a0 d11223344 st10", imem_we, imem_addr, imem_wdata, status); end
    tick(); tick();
    checks++; if (wr_cnt - base !== 1 || wr_data[base] !== 32'h11223344) begin
      failures++; $display("FAIL b2b_count got=n%0d exp=n1", wr_cnt - base); end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero();
    test_err();
    test_max_count();
    test_reset_mid();
    test_ignore_bytes();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
